spi_shift_engine: RTL
=====================

# spi_shift_engine

Serial bit engine for the APB4 SPI controller, downstream of the TX FIFO and upstream of the RX FIFO. It pops TX words, shifts them out on a single MOSI line in SPI modes 0-3 with a programmable SCK divider, and samples MISO into RX words. It drives chip-selects and reports busy/last status back to the control register file, which clears the start bit on `busy_o && last_o`.

## Interface
- `DATA_WIDTH`, 32: TX/RX word width.
- `DIV_WIDTH`, 8: clock divider width.
- `TRL_WIDTH`, 16: transfer length field width.
- `NSS_WIDTH`, 4: number of chip-select lines.

Ports:
- `clk_i`  in  1  clock; every flop is on its rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `st_i`  in  1  start level.
- `cpol_i`, `cpha_i`, `lsb_i`  in  1 each  SPI mode bits and LSB-first flag.
- `div_i`  in  DIV_WIDTH  SCK half-period minus 1, in clk cycles.
- `dsize_i`  in  2  frame size: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- `trl_i`  in  TRL_WIDTH  frames per transfer minus 1.
- `nss_i`  in  NSS_WIDTH  chip-select mask (1 = assert that line).
- `busy_o`  out  1  transfer in progress.
- `last_o`  out  1  one-cycle pulse marking the final cycle of a transfer.
- `tx_valid_i`  in  1; `tx_ready_o`  out  1; `tx_data_i`  in  DATA_WIDTH  TX pop handshake.
- `rx_valid_o`  out  1; `rx_ready_i`  in  1; `rx_data_o`  out  DATA_WIDTH  RX push handshake.
- `spi_sck_o`  out  1  serial clock.
- `spi_nss_o`  out  NSS_WIDTH  chip-selects, active-low.
- `spi_mosi_o`  out  1  serial data out.
- `spi_miso_i`  in  1  serial data in.

## Operation
- **IDLE**
  - `st_i` = 1 latches `cpol_i`, `cpha_i`, `lsb_i`, `div_i`, `dsize_i`, `trl_i` and `nss_i`, loads the frame counter, and moves to SETUP.
  - Later changes to these inputs have no effect until the next start.
- **SETUP**
  - `spi_nss_o` = ~nss.
  - Holds for one half-period, then goes to LOAD.
- **LOAD**
  - Waits for `tx_valid_i`.
  - On valid: `tx_ready_o` = 1 for exactly that cycle, the shift register loads `tx_data_i`, then SHIFT.
  - Only the low nbits are used, where nbits = 8*(dsize+1).
- **SHIFT**
  - Produces 2*nbits SCK edges, one per half-period.
  - CPHA = 0:
    - The first bit is on MOSI at SHIFT entry.
    - Sample on leading edges; shift on trailing edges.
  - CPHA = 1:
    - Shift on leading edges; sample on trailing edges.
  - Bit order:
    - MSB-first sends bit nbits-1 first.
    - LSB-first sends bit 0 first.
  - RX data is right-aligned in nbits and zero-extended to DATA_WIDTH.
  - After the final edge, go to PUSH.
- **PUSH**
  - `rx_valid_o` = 1, `rx_data_o` stable, held until `rx_ready_i`.
  - On handshake:
    - Frame counter nonzero: decrement and go to LOAD.
    - Frame counter zero: go to HOLD.
- **HOLD**
  - Keeps CS asserted for one half-period, then deasserts CS.
  - `last_o` = 1 for one cycle with `busy_o` = 1, then IDLE.
- Stalls in LOAD (TX empty) or PUSH (RX full):
  - SCK stays at cpol and CS stays asserted.
  - The divider counter is held at 0.
- `busy_o` is 1 in every state except IDLE.

## Timing
- **Reset values**
  - State IDLE.
  - `spi_sck_o` = 0, `spi_nss_o` = all ones, `spi_mosi_o` = 0.
  - `busy_o`, `last_o`, `tx_ready_o`, `rx_valid_o` = 0; `rx_data_o` = 0.
- **Reset mid-transfer:** all outputs return to their reset values immediately, with no RX push or TX pop.
- **Registered outputs:** all outputs are registered.
  - In IDLE, `spi_sck_o` follows `cpol_i` with one cycle of delay.
- **Divider:** counter 0..div; an SCK edge occurs when counter == div.
  - div = 0 gives SCK = clk/2.
  - div = 255 gives 256-cycle half-periods.
- **Start latency:** the cycle after `st_i` is seen in IDLE, `busy_o` = 1 and CS is asserted.
- **Frame length** with no stalls: 1 LOAD cycle + 2*nbits*(div+1) SHIFT cycles + 1 PUSH cycle.
- **Back-to-back starts:** `st_i` still high in the cycle after `last_o` starts a new transfer. The controller clears `st_i` on the `last_o` cycle, so this does not happen in the system.
- **Frame counter width:** trl = 0 means 1 frame; trl = 2^TRL_WIDTH-1 transfers 2^TRL_WIDTH frames with no wrap.
- **Simultaneous TX and RX handshakes** cannot occur, because LOAD and PUSH are distinct states.

## Test plan
- Mode 0, MSB-first, div = 0, dsize = 0, trl = 0, TX 0xA5, MISO looped to MOSI:
  - MOSI 1,0,1,0,0,1,0,1 on 16 edges.
  - `rx_data_o` = 0x000000A5; one `last_o` pulse; CS high afterwards.
- Modes 1, 2 and 3, LSB-first, dsize = 3, TX 0x12345678, loopback:
  - SCK idles at cpol.
  - Sampling falls on the correct edge for each mode.
  - RX = 0x12345678.
- div = 3, 16-bit frame: each SCK half-period is 4 clk; frame SHIFT lasts 128 cycles.
- trl = 2 with the TX FIFO empty for 50 cycles before the second word:
  - Three pops; SCK frozen at cpol and CS held low during the gap.
  - Three RX pushes, then `last_o`.
- `rx_ready_i` held low 20 cycles at the first PUSH: `rx_valid_o` and the data stay stable; no SCK edges until ready.
- `rst_n_i` asserted mid-SHIFT: outputs return to reset values asynchronously, no `rx_valid_o`; a new start works normally.

Source files
------------

// File: rtl/spi_shift_engine_if.sv
// Control, TX-pop, RX-push and SPI pad signals of the shift engine, grouped into one bundle.
// master = the engine itself; slave = controller / FIFOs / pads around it.
interface spi_shift_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int TRL_WIDTH  = 16,
    parameter int NSS_WIDTH  = 4
);
    logic                  st_i;
    logic                  cpol_i;
    logic                  cpha_i;
    logic                  lsb_i;
    logic [DIV_WIDTH-1:0]  div_i;
    logic [1:0]            dsize_i;
    logic [TRL_WIDTH-1:0]  trl_i;
    logic [NSS_WIDTH-1:0]  nss_i;
    logic                  busy_o;
    logic                  last_o;
    logic                  tx_valid_i;
    logic                  tx_ready_o;
    logic [DATA_WIDTH-1:0] tx_data_i;
    logic                  rx_valid_o;
    logic                  rx_ready_i;
    logic [DATA_WIDTH-1:0] rx_data_o;
    logic                  spi_sck_o;
    logic [NSS_WIDTH-1:0]  spi_nss_o;
    logic                  spi_mosi_o;
    logic                  spi_miso_i;

    modport master (
        input  st_i, cpol_i, cpha_i, lsb_i, div_i, dsize_i, trl_i, nss_i,
        input  tx_valid_i, tx_data_i, rx_ready_i, spi_miso_i,
        output busy_o, last_o, tx_ready_o, rx_valid_o, rx_data_o,
        output spi_sck_o, spi_nss_o, spi_mosi_o
    );

    modport slave (
        output st_i, cpol_i, cpha_i, lsb_i, div_i, dsize_i, trl_i, nss_i,
        output tx_valid_i, tx_data_i, rx_ready_i, spi_miso_i,
        input  busy_o, last_o, tx_ready_o, rx_valid_o, rx_data_o,
        input  spi_sck_o, spi_nss_o, spi_mosi_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode 0-3 bit engine: per frame 1 LOAD + 2*nbits*(div+1) SHIFT + 1 PUSH cycles, all outputs registered.
// TX empty stalls in LOAD, RX full stalls in PUSH; SCK parks at cpol and CS stays asserted while stalled.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 8,
    parameter int TRL_WIDTH  = 16,
    parameter int NSS_WIDTH  = 4
) (
    input logic                clk_i,
    input logic                rst_n_i,
    spi_shift_engine_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_PUSH, S_HOLD, S_LAST
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [5:0]            edge_q, edge_d;
    logic [TRL_WIDTH-1:0]  frame_q, frame_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [1:0]            dsize_q, dsize_d;
    logic [NSS_WIDTH-1:0]  nss_q, nss_d;
    logic                  sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, last_q, last_d;
    logic                  txr_q, txr_d, rxv_q, rxv_d;

    logic [4:0] top_bit;
    logic [4:0] bit_num;
    logic       half_done;

    // {dsize,3'b111} is nbits-1; each bit occupies a leading and a trailing edge.
    assign top_bit   = {dsize_q, 3'b111};
    assign bit_num   = edge_q[5:1];
    assign half_done = (cnt_q == div_q);

    function automatic logic [4:0] bit_pos(input logic [4:0] idx, input logic lsb_first,
                                           input logic [4:0] top);
        return lsb_first ? idx : top - idx;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        edge_d    = edge_q;
        frame_d   = frame_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        dsize_d   = dsize_q;
        nss_d     = nss_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        last_d    = 1'b0;
        txr_d     = txr_q;
        rxv_d     = rxv_q;

        case (state_q)
            S_IDLE: begin
                sck_d  = bus.cpol_i;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (bus.st_i) begin
                    cpol_d  = bus.cpol_i;
                    cpha_d  = bus.cpha_i;
                    lsb_d   = bus.lsb_i;
                    div_d   = bus.div_i;
                    dsize_d = bus.dsize_i;
                    frame_d = bus.trl_i;
                    nss_d   = ~bus.nss_i;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                cnt_d = half_done ? '0 : cnt_q + 1'b1;
                if (half_done) begin
                    txr_d   = 1'b1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                cnt_d = '0;
                if (bus.tx_valid_i && txr_q) begin
                    tx_sh_d = bus.tx_data_i;
                    rx_sh_d = '0;
                    txr_d   = 1'b0;
                    edge_d  = '0;
                    // CPHA=0 needs the first bit on the line before the first edge.
                    if (!cpha_q)
                        mosi_d = bus.tx_data_i[bit_pos(5'd0, lsb_q, top_bit)];
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                cnt_d = half_done ? '0 : cnt_q + 1'b1;
                if (half_done) begin
                    sck_d  = ~sck_q;
                    edge_d = edge_q + 6'd1;
                    // edge_q[0]==0 is a leading edge; CPHA selects which edge samples.
                    if (edge_q[0] == cpha_q)
                        rx_sh_d[bit_pos(bit_num, lsb_q, top_bit)] = bus.spi_miso_i;
                    else if (cpha_q)
                        mosi_d = tx_sh_q[bit_pos(bit_num, lsb_q, top_bit)];
                    else if (bit_num != top_bit)
                        mosi_d = tx_sh_q[bit_pos(bit_num + 5'd1, lsb_q, top_bit)];
                    if (edge_q == {dsize_q, 4'hF}) begin
                        rx_data_d = rx_sh_d;
                        rxv_d     = 1'b1;
                        state_d   = S_PUSH;
                    end
                end
            end

            S_PUSH: begin
                cnt_d = '0;
                if (bus.rx_ready_i && rxv_q) begin
                    rxv_d = 1'b0;
                    if (frame_q != '0) begin
                        frame_d = frame_q - 1'b1;
                        txr_d   = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                cnt_d = half_done ? '0 : cnt_q + 1'b1;
                if (half_done) begin
                    nss_d   = '1;
                    last_d  = 1'b1;
                    state_d = S_LAST;
                end
            end

            S_LAST: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            edge_q    <= '0;
            frame_q   <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            dsize_q   <= '0;
            nss_q     <= '1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b0;
            txr_q     <= 1'b0;
            rxv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            frame_q   <= frame_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            dsize_q   <= dsize_d;
            nss_q     <= nss_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
            txr_q     <= txr_d;
            rxv_q     <= rxv_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.last_o     = last_q;
    assign bus.tx_ready_o = txr_q;
    assign bus.rx_valid_o = rxv_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.spi_sck_o  = sck_q;
    assign bus.spi_nss_o  = nss_q;
    assign bus.spi_mosi_o = mosi_q;
endmodule
